// File: rtl/led_blink_pkg.sv
// Shared types and default constants for the multi-channel LED activity generator.
// The optional PWM brightness stage is enabled by defining LED_BLINK_PWM_EN.
package led_blink_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_ONESHOT = 2'd3
    } led_mode_e;

    localparam int NCH_DEF   = 4;
    localparam int CNT_W_DEF = 26;
    localparam int PWM_W_DEF = 4;

    // LED level a channel takes on the cycle it enters a mode.
    function automatic logic mode_init_led(input led_mode_e m);
        logic v;
        case (m)
            LED_OFF:     v = 1'b0;
            LED_ON:      v = 1'b1;
            LED_BLINK:   v = 1'b0;
            LED_ONESHOT: v = 1'b0;
            default:     v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: half-period counter, previous-mode register, one-shot flag,
// registered LED state and registered event tick.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  led_mode_e        mode,
    input  logic [CNT_W-1:0] half_period,
    input  logic             trig,
    output logic             led,
    output logic             tick
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    led_mode_e        prev_mode_q;
    led_mode_e        prev_mode_d;
    logic             os_q;
    logic             os_d;
    logic             led_q;
    logic             led_d;
    logic             tick_q;
    logic             tick_d;
    logic             hp_zero_s;
    logic             expired_s;

    assign hp_zero_s = (half_period == {CNT_W{1'b0}});
    // Compared before the increment, so shrinking half_period fires on the next enabled cycle.
    assign expired_s = (cnt_q >= half_period);

    // Next-state logic: mode change first, then enable gating, then per-mode behaviour.
    always_comb begin
        cnt_d       = cnt_q;
        prev_mode_d = prev_mode_q;
        os_d        = os_q;
        led_d       = led_q;
        tick_d      = 1'b0;
        if (mode != prev_mode_q) begin
            prev_mode_d = mode;
            cnt_d       = CntOne;
            os_d        = 1'b0;
            led_d       = mode_init_led(mode);
        end else if (!en) begin
            cnt_d = cnt_q;
        end else begin
            case (mode)
                LED_OFF: begin
                    led_d = 1'b0;
                    cnt_d = CntOne;
                    os_d  = 1'b0;
                end
                LED_ON: begin
                    led_d = 1'b1;
                    cnt_d = CntOne;
                    os_d  = 1'b0;
                end
                LED_BLINK: begin
                    if (hp_zero_s) begin
                        led_d = 1'b0;
                        cnt_d = CntOne;
                    end else if (expired_s) begin
                        led_d  = ~led_q;
                        tick_d = 1'b1;
                        cnt_d  = CntOne;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                LED_ONESHOT: begin
                    // A trigger outranks expiry in the same cycle.
                    if (trig && !hp_zero_s) begin
                        led_d = 1'b1;
                        cnt_d = CntOne;
                        os_d  = 1'b1;
                    end else if (os_q) begin
                        if (expired_s) begin
                            led_d  = 1'b0;
                            tick_d = 1'b1;
                            os_d   = 1'b0;
                            cnt_d  = CntOne;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end else begin
                        led_d = 1'b0;
                        cnt_d = CntOne;
                    end
                end
                default: begin
                    led_d = 1'b0;
                    cnt_d = CntOne;
                    os_d  = 1'b0;
                end
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= CntOne;
            prev_mode_q <= LED_OFF;
            os_q        <= 1'b0;
            led_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            prev_mode_q <= prev_mode_d;
            os_q        <= os_d;
            led_q       <= led_d;
            tick_q      <= tick_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule

// File: rtl/led_blink_multi.sv
// NCH-channel LED activity generator: slices the packed buses into channels.
// Define LED_BLINK_PWM_EN to add the bright input and a shared PWM brightness stage.
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int CNT_W = CNT_W_DEF
`ifdef LED_BLINK_PWM_EN
    ,
    parameter int PWM_W = PWM_W_DEF
`endif
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 en,
    input  logic [2*NCH-1:0]     mode,
    input  logic [CNT_W*NCH-1:0] half_period,
    input  logic [NCH-1:0]       trig,
`ifdef LED_BLINK_PWM_EN
    input  logic [PWM_W*NCH-1:0] bright,
`endif
    output logic [NCH-1:0]       led,
    output logic [NCH-1:0]       tick
);

    logic [NCH-1:0] chan_led_s;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        led_blink_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk        (sys_clk),
            .rst_n      (sys_rst_n),
            .en         (en),
            .mode       (led_mode_e'(mode[2*i +: 2])),
            .half_period(half_period[CNT_W*i +: CNT_W]),
            .trig       (trig[i]),
            .led        (chan_led_s[i]),
            .tick       (tick[i])
        );
    end

`ifdef LED_BLINK_PWM_EN
    localparam logic [PWM_W-1:0] PwmOne = {{(PWM_W-1){1'b0}}, 1'b1};

    logic [PWM_W-1:0] pwm_cnt_q;
    logic [PWM_W-1:0] pwm_cnt_d;
    logic [NCH-1:0]   led_q;
    logic [NCH-1:0]   led_d;

    // Shared brightness counter and per-channel duty gating.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        led_d     = {NCH{1'b0}};
        if (en) begin
            pwm_cnt_d = pwm_cnt_q + PwmOne;
        end else begin
            pwm_cnt_d = pwm_cnt_q;
        end
        for (int i = 0; i < NCH; i++) begin
            led_d[i] = chan_led_s[i] & (pwm_cnt_q < bright[PWM_W*i +: PWM_W]);
        end
    end

    // PWM counter and gated LED registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_q <= {PWM_W{1'b0}};
            led_q     <= {NCH{1'b0}};
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;
`else
    assign led = chan_led_s;
`endif

endmodule

// File: tb/tb_led_blink_multi.sv
// Self-checking bench for led_blink_multi (default build): directed scenarios
// with literal expectations, then randomized traffic against a behavioural model.
module tb_led_blink_multi;

    localparam int NCH   = 4;
    localparam int CNT_W = 26;

    logic                 sys_clk;
    logic                 sys_rst_n;
    logic                 en;
    logic [2*NCH-1:0]     mode;
    logic [CNT_W*NCH-1:0] half_period;
    logic [NCH-1:0]       trig;
    logic [NCH-1:0]       led;
    logic [NCH-1:0]       tick;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    // Model: per channel, the mode last seen, LED level, tick, one-shot armed flag,
    // and how many enabled cycles have elapsed in the current phase.
    int m_prev [NCH];
    int m_led  [NCH];
    int m_tick [NCH];
    int m_os   [NCH];
    int m_age  [NCH];

    led_blink_multi #(
        .NCH  (NCH),
        .CNT_W(CNT_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .en         (en),
        .mode       (mode),
        .half_period(half_period),
        .trig       (trig),
        .led        (led),
        .tick       (tick)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_prev[c] = 0;
            m_led[c]  = 0;
            m_tick[c] = 0;
            m_os[c]   = 0;
            m_age[c]  = 0;
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int md;
        int hp;
        if (!sys_rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            md = int'(mode[2*c +: 2]);
            hp = int'(half_period[CNT_W*c +: CNT_W]);
            m_tick[c] = 0;
            if (md != m_prev[c]) begin
                m_prev[c] = md;
                m_age[c]  = 0;
                m_os[c]   = 0;
                m_led[c]  = (md == 1) ? 1 : 0;
            end else if (en) begin
                if (md == 0 || md == 1) begin
                    m_led[c] = md;
                    m_age[c] = 0;
                end else if (md == 2) begin
                    if (hp == 0) begin
                        m_led[c] = 0;
                        m_age[c] = 0;
                    end else if (m_age[c] + 1 >= hp) begin
                        m_led[c]  = 1 - m_led[c];
                        m_tick[c] = 1;
                        m_age[c]  = 0;
                    end else begin
                        m_age[c]++;
                    end
                end else begin
                    if (trig[c] && hp != 0) begin
                        m_led[c] = 1;
                        m_os[c]  = 1;
                        m_age[c] = 0;
                    end else if (m_os[c] != 0) begin
                        if (m_age[c] + 1 >= hp) begin
                            m_led[c]  = 0;
                            m_tick[c] = 1;
                            m_os[c]   = 0;
                            m_age[c]  = 0;
                        end else begin
                            m_age[c]++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        model_step();
        #1;
    endtask

    task automatic set_mode(input int c, input int m);
        logic [1:0] v;
        v = m[1:0];
        mode[2*c +: 2] = v;
    endtask

    task automatic set_hp(input int c, input int v);
        logic [CNT_W-1:0] w;
        w = v[CNT_W-1:0];
        half_period[CNT_W*c +: CNT_W] = w;
    endtask

    // Continuous comparison of every channel against the model.
    always @(negedge sys_clk) begin
        if (chk_on) begin
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("model_led[%0d]", c), 32'(led[c]), m_led[c]);
                check($sformatf("model_tick[%0d]", c), 32'(tick[c]), m_tick[c]);
            end
        end
    end

    task automatic async_reset();
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_led_immediate", 32'(led), 32'd0);
        check("rst_tick_immediate", 32'(tick), 32'd0);
        repeat (3) cycle();
        mode = {NCH{2'd1}};
        #2;
        sys_rst_n = 1'b1;
        cycle();
        check("on_after_reset", 32'(led), 32'hF);
    endtask

    initial begin
        int ticks;
        int toggles;
        int first_tick;
        int last_tick;
        int prev_led;
        int high_n;
        int tick_n;
        int led_at_tick;
        int saved;

        sys_rst_n   = 1'b1;
        en          = 1'b0;
        mode        = '0;
        half_period = '0;
        trig        = '0;
        #1;
        sys_rst_n = 1'b0;
        model_reset();
        chk_on = 1'b1;
        #1;
        check("init_rst_led", 32'(led), 32'd0);
        repeat (2) cycle();
        sys_rst_n = 1'b1;
        en        = 1'b1;
        cycle();
        check("off_led", 32'(led), 32'd0);

        // Blink, half-period 5 on channel 0.
        set_hp(0, 5);
        set_mode(0, 2);
        cycle();
        check("blink_entry_led", 32'(led[0]), 32'd0);
        ticks = 0; toggles = 0; first_tick = -1; last_tick = -1; prev_led = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (tick[0]) begin
                ticks++;
                if (first_tick < 0) first_tick = k;
                last_tick = k;
            end
            if (int'(led[0]) != prev_led) toggles++;
            prev_led = int'(led[0]);
        end
        check("blink_ticks", ticks, 6);
        check("blink_toggles", toggles, 6);
        check("blink_first_tick", first_tick, 5);
        check("blink_last_tick", last_tick, 30);

        // Freeze with counter at 3, then resume.
        repeat (2) cycle();
        en = 1'b0;
        saved = int'(led[0]);
        ticks = 0;
        repeat (20) begin
            cycle();
            if (tick[0]) ticks++;
        end
        check("freeze_ticks", ticks, 0);
        check("freeze_led", 32'(led[0]), saved);
        en = 1'b1;
        cycle();
        check("resume_tick1", 32'(tick[0]), 32'd0);
        cycle();
        check("resume_tick2", 32'(tick[0]), 32'd0);
        cycle();
        check("resume_tick3", 32'(tick[0]), 32'd1);

        // Half-period shrink on channel 1 when the counter reads 50.
        set_hp(1, 100);
        set_mode(1, 2);
        cycle();
        repeat (49) cycle();
        set_hp(1, 3);
        cycle();
        check("shrink_tick", 32'(tick[1]), 32'd1);
        check("shrink_led", 32'(led[1]), 32'd1);
        repeat (2) cycle();
        check("shrink_gap", 32'(tick[1]), 32'd0);
        cycle();
        check("shrink_next", 32'(tick[1]), 32'd1);
        check("shrink_led2", 32'(led[1]), 32'd0);

        // One-shot with retrigger on channel 2.
        set_hp(2, 8);
        set_mode(2, 3);
        cycle();
        trig[2] = 1'b1;
        cycle();
        trig[2] = 1'b0;
        check("os_rise", 32'(led[2]), 32'd1);
        high_n = 1;
        repeat (4) begin
            cycle();
            if (led[2]) high_n++;
        end
        trig[2] = 1'b1;
        cycle();
        trig[2] = 1'b0;
        if (led[2]) high_n++;
        tick_n = 0; led_at_tick = -1;
        repeat (20) begin
            cycle();
            if (led[2]) high_n++;
            if (tick[2]) begin
                tick_n++;
                led_at_tick = int'(led[2]);
            end
        end
        check("os_high_cycles", high_n, 13);
        check("os_tick_count", tick_n, 1);
        check("os_led_at_tick", led_at_tick, 0);

        // Trigger coinciding with expiry keeps the LED lit.
        trig[2] = 1'b1;
        cycle();
        trig[2] = 1'b0;
        repeat (7) cycle();
        trig[2] = 1'b1;
        cycle();
        trig[2] = 1'b0;
        check("os_trig_at_expiry_led", 32'(led[2]), 32'd1);
        check("os_trig_at_expiry_tick", 32'(tick[2]), 32'd0);
        repeat (10) cycle();

        async_reset();

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < NCH; c++) set_hp(c, $urandom_range(1, 6));
        for (int n = 0; n < 1600; n++) begin
            en = ($urandom_range(0, 7) != 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 31) == 0) set_mode(c, $urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) set_hp(c, $urandom_range(0, 9));
                trig[c] = ($urandom_range(0, 3) == 0);
            end
            cycle();
            if (n == 800) async_reset();
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
